// File: rtl/mig_seq_eval.sv
// Time-multiplexed majority-inverter-graph evaluator: a programmable node list is
// evaluated one majority node per clock for each accepted input vector.
module mig_seq_eval #(
  parameter int NUM_IN    = 4,
  parameter int MAX_NODES = 16,
  parameter int IW        = $clog2(1 + NUM_IN + MAX_NODES),
  parameter int AW        = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [3*(IW+1)-1:0]   cfg_node,
  input  logic                  len_we,
  input  logic [AW:0]           len,
  input  logic [IW:0]           out_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_IN-1:0]     in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  y
);

  localparam int OW = IW + 1;
  localparam int NW = 3 * OW;
  localparam int PW = 2 ** IW;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_NODES);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state, state_next;

  logic [NW-1:0]        node_mem [MAX_NODES];
  logic [AW:0]          len_q;
  logic [AW:0]          k;
  logic [IW:0]          sel_q;
  logic [NUM_IN-1:0]    x_q;
  logic [MAX_NODES-1:0] nval, nval_next;
  logic                 y_q;

  logic                 accept;
  logic                 enter_done;
  logic [AW:0]          len_sat, len_eff;
  logic [IW:0]          sel_eff, sel_src;
  logic [NUM_IN-1:0]    x_src;
  logic [NW-1:0]        cur;
  logic [PW-1:0]        val_pad, res_pad;
  logic                 op_a, op_b, op_c, maj;
  logic                 y_next;

  // Signal vector zero-padded to the full index range so out-of-range indices read 0.
  function automatic logic rd(input logic [PW-1:0] v, input logic [IW:0] op);
    return v[op[IW-1:0]] ^ op[IW];
  endfunction

  assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
  assign len_eff = len_we ? len_sat : len_q;
  assign sel_eff = len_we ? out_sel : sel_q;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = (len_eff == '0) ? DONE : EVAL;
        end
      end
      EVAL: begin
        if (k == len_q - 1'b1) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_done = (state_next == DONE) && (state != DONE);

  always_comb begin
    cur     = node_mem[k[AW-1:0]];
    val_pad = PW'({nval, x_q, 1'b0});
    op_a    = rd(val_pad, cur[OW-1:0]);
    op_b    = rd(val_pad, cur[2*OW-1:OW]);
    op_c    = rd(val_pad, cur[3*OW-1:2*OW]);
    maj     = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
  end

  always_comb begin
    nval_next = nval;
    if (accept) begin
      nval_next = '0;
    end else if (state == EVAL) begin
      nval_next[k[AW-1:0]] = maj;
    end
  end

  // The result is taken from the values being written this edge, so a len=0
  // vector (straight from IDLE) and the last EVAL node share one path.
  always_comb begin
    x_src   = (state == IDLE) ? in_x : x_q;
    sel_src = (state == IDLE) ? sel_eff : sel_q;
    res_pad = PW'({nval_next, x_src, 1'b0});
    y_next  = rd(res_pad, sel_src);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_NODES; i++) node_mem[i] <= '0;
      len_q <= '0;
      sel_q <= '0;
      x_q   <= '0;
      k     <= '0;
      nval  <= '0;
      y_q   <= 1'b0;
    end else begin
      if (state == IDLE && cfg_we) node_mem[cfg_addr] <= cfg_node;
      if (state == IDLE && len_we) begin
        len_q <= len_sat;
        sel_q <= out_sel;
      end
      if (accept) begin
        x_q <= in_x;
        k   <= '0;
      end else if (state == EVAL) begin
        k <= k + 1'b1;
      end
      nval <= nval_next;
      if (enter_done) y_q <= y_next;
    end
  end

  assign y = y_q;

endmodule
